// File: rtl/seq_shift_unit_if.sv
// Request/result bundle for seq_shift_unit: operand, op and shift amount in; result and status out.
// The requester drives the master side; the shift unit sits on the slave side.
interface seq_shift_unit_if #(
  parameter int N   = 32,
  parameter int SHW = 5
);
  logic           start;
  logic [2:0]     op;
  logic [N-1:0]   value;
  logic [SHW-1:0] shamt;
  logic           MSB;
  logic           LSB;
  logic [N-1:0]   Q;
  logic           busy;
  logic           done;
  logic           carry_out;

  modport master (
    output start, op, value, shamt, MSB, LSB,
    input  Q, busy, done, carry_out
  );

  modport slave (
    input  start, op, value, shamt, MSB, LSB,
    output Q, busy, done, carry_out
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter, up to STEP bits/cycle; done pulses ceil(shamt/STEP)+1 cycles after capture.
// start is taken only in IDLE/DONE and ignored while busy; all outputs are registered.
module seq_shift_unit #(
  parameter int N    = 32,
  parameter int SHW  = 5,
  parameter int STEP = 1
) (
  input  logic               CLK,
  input  logic               Clear,
  seq_shift_unit_if.slave    bus
);
  localparam int SW = SHW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [2:0] {
    OP_SLL = 3'd0, OP_SRL = 3'd1, OP_SRA = 3'd2, OP_ROL = 3'd3,
    OP_ROR = 3'd4, OP_SLS = 3'd5, OP_SRS = 3'd6, OP_RSV = 3'd7
  } op_e;

  state_e         state_q, state_nx;
  logic [N-1:0]   q_q, q_nx;
  logic           co_q, co_nx;
  logic [2:0]     op_q, op_nx;
  logic [SHW-1:0] rem_q, rem_nx;
  logic           busy_q, done_q;
  logic [SW-1:0]  step_s;
  logic [N-1:0]   sh_q;
  logic           sh_co;

  assign bus.Q         = q_q;
  assign bus.carry_out = co_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // A STEP-bit shift is built from s single-bit shifts, so fill and carry rules stay per-bit.
  always_comb begin
    step_s = ({1'b0, rem_q} < SW'(STEP)) ? {1'b0, rem_q} : SW'(STEP);
    sh_q   = q_q;
    sh_co  = co_q;
    for (int i = 0; i < STEP; i++) begin
      if (SW'(i) < step_s) begin
        case (op_q)
          OP_SLL: begin sh_co = sh_q[N-1]; sh_q = {sh_q[N-2:0], 1'b0};       end
          OP_SRL: begin sh_co = sh_q[0];   sh_q = {1'b0, sh_q[N-1:1]};       end
          OP_SRA: begin sh_co = sh_q[0];   sh_q = {sh_q[N-1], sh_q[N-1:1]};  end
          OP_ROL: begin sh_co = sh_q[N-1]; sh_q = {sh_q[N-2:0], sh_q[N-1]};  end
          OP_ROR: begin sh_co = sh_q[0];   sh_q = {sh_q[0], sh_q[N-1:1]};    end
          OP_SLS: begin sh_co = sh_q[N-1]; sh_q = {sh_q[N-2:0], bus.LSB};    end
          OP_SRS: begin sh_co = sh_q[0];   sh_q = {bus.MSB, sh_q[N-1:1]};    end
          default: begin sh_co = 1'b0;     sh_q = sh_q;                      end
        endcase
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    q_nx     = q_q;
    co_nx    = co_q;
    op_nx    = op_q;
    rem_nx   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          q_nx     = bus.value;
          co_nx    = 1'b0;
          op_nx    = bus.op;
          rem_nx   = bus.shamt;
          state_nx = (bus.shamt != '0) ? SHIFT : DONE;
        end else if (state_q == DONE) begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        q_nx   = sh_q;
        co_nx  = sh_co;
        rem_nx = rem_q - step_s[SHW-1:0];
        if (rem_nx == '0) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      state_q <= IDLE;
      q_q     <= '0;
      co_q    <= 1'b0;
      op_q    <= 3'd0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      q_q     <= q_nx;
      co_q    <= co_nx;
      op_q    <= op_nx;
      rem_q   <= rem_nx;
      busy_q  <= (state_nx == SHIFT);
      done_q  <= (state_nx == DONE);
    end
  end
endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: an 8-bit STEP=1 unit driven from a vector table plus
// hand-written corner sequences, and a 32-bit STEP=4 unit for multi-bit steps.
module tb_seq_shift_unit;
  logic CLK = 1'b0;
  logic Clear = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  seq_shift_unit_if #(.N(8),  .SHW(3)) b8  ();
  seq_shift_unit_if #(.N(32), .SHW(5)) b32 ();

  seq_shift_unit #(.N(8),  .SHW(3), .STEP(1)) dut8  (.CLK(CLK), .Clear(Clear), .bus(b8));
  seq_shift_unit #(.N(32), .SHW(5), .STEP(4)) dut32 (.CLK(CLK), .Clear(Clear), .bus(b32));

  typedef struct {
    logic [2:0] op;
    logic [7:0] v;
    logic [2:0] sh;
    logic       ms;
    logic       ls;
    logic [7:0] q;
    logic       co;
    int         cyc;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run8(input int idx, input vec_t t);
    int n;
    int nb;
    b8.start = 1'b1; b8.op = t.op; b8.value = t.v; b8.shamt = t.sh;
    b8.MSB = t.ms; b8.LSB = t.ls;
    tick();
    b8.start = 1'b0;
    n = 0; nb = 0;
    while (!b8.done && n < 64) begin
      if (b8.busy) nb++;
      tick();
      n++;
    end
    chk($sformatf("v%0d_cycles", idx), n, t.cyc);
    chk($sformatf("v%0d_busy", idx), nb, t.cyc);
    chk($sformatf("v%0d_Q", idx), {24'd0, b8.Q}, {24'd0, t.q});
    chk($sformatf("v%0d_carry", idx), {31'd0, b8.carry_out}, {31'd0, t.co});
    tick();
  endtask

  task automatic run32(input string nm, input logic [2:0] op, input logic [31:0] v,
                       input logic [4:0] sh, input logic [31:0] eq, input logic eco,
                       input int ecyc);
    int n;
    b32.start = 1'b1; b32.op = op; b32.value = v; b32.shamt = sh;
    tick();
    b32.start = 1'b0;
    n = 0;
    while (!b32.done && n < 64) begin
      tick();
      n++;
    end
    chk({nm, "_cycles"}, n, ecyc);
    chk({nm, "_Q"}, b32.Q, eq);
    chk({nm, "_carry"}, {31'd0, b32.carry_out}, {31'd0, eco});
    tick();
  endtask

  initial begin
    //             op    value  sh   MSB   LSB   Q      co    cycles
    tbl[0]  = '{3'd2, 8'h96, 3'd3, 1'b0, 1'b0, 8'hF2, 1'b1, 3};
    tbl[1]  = '{3'd3, 8'h81, 3'd1, 1'b0, 1'b0, 8'h03, 1'b1, 1};
    tbl[2]  = '{3'd0, 8'hA5, 3'd0, 1'b0, 1'b0, 8'hA5, 1'b0, 0};
    tbl[3]  = '{3'd1, 8'hF0, 3'd4, 1'b0, 1'b0, 8'h0F, 1'b0, 4};
    tbl[4]  = '{3'd0, 8'h25, 3'd2, 1'b0, 1'b0, 8'h94, 1'b0, 2};
    tbl[5]  = '{3'd4, 8'h01, 3'd1, 1'b0, 1'b0, 8'h80, 1'b1, 1};
    tbl[6]  = '{3'd0, 8'h81, 3'd1, 1'b0, 1'b0, 8'h02, 1'b1, 1};
    tbl[7]  = '{3'd1, 8'h81, 3'd7, 1'b0, 1'b0, 8'h01, 1'b0, 7};
    tbl[8]  = '{3'd4, 8'hB4, 3'd3, 1'b0, 1'b0, 8'h96, 1'b1, 3};
    tbl[9]  = '{3'd2, 8'h40, 3'd6, 1'b0, 1'b0, 8'h01, 1'b0, 6};
    tbl[10] = '{3'd7, 8'h3C, 3'd3, 1'b0, 1'b0, 8'h3C, 1'b0, 3};
    tbl[11] = '{3'd5, 8'h00, 3'd3, 1'b0, 1'b1, 8'h07, 1'b0, 3};
    tbl[12] = '{3'd6, 8'hFF, 3'd2, 1'b0, 1'b0, 8'h3F, 1'b1, 2};
    tbl[13] = '{3'd3, 8'h80, 3'd7, 1'b0, 1'b0, 8'h40, 1'b0, 7};

    b8.start = 1'b0;  b8.op = 3'd0;  b8.value = '0;  b8.shamt = '0;  b8.MSB = 1'b0;  b8.LSB = 1'b0;
    b32.start = 1'b0; b32.op = 3'd0; b32.value = '0; b32.shamt = '0; b32.MSB = 1'b0; b32.LSB = 1'b0;

    #2;
    chk("rst_Q", {24'd0, b8.Q}, 32'd0);
    chk("rst_busy", {31'd0, b8.busy}, 32'd0);
    chk("rst_done", {31'd0, b8.done}, 32'd0);
    chk("rst_carry", {31'd0, b8.carry_out}, 32'd0);
    #10 Clear = 1'b1;
    tick();

    // Clear asserted mid-SHIFT must empty everything without a clock edge.
    b8.start = 1'b1; b8.op = 3'd3; b8.value = 8'h2D; b8.shamt = 3'd7;
    tick();
    b8.start = 1'b0;
    tick();
    chk("mid_Q", {24'd0, b8.Q}, 32'h5A);
    chk("mid_busy", {31'd0, b8.busy}, 32'd1);
    #3 Clear = 1'b0;
    #1;
    chk("async_Q", {24'd0, b8.Q}, 32'd0);
    chk("async_busy", {31'd0, b8.busy}, 32'd0);
    chk("async_done", {31'd0, b8.done}, 32'd0);
    chk("async_carry", {31'd0, b8.carry_out}, 32'd0);
    #2 Clear = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, b8.busy}, 32'd0);

    for (int i = 0; i < 14; i++) run8(i, tbl[i]);

    // Serial SRS with MSB changing per edge; a start during SHIFT must be ignored.
    b8.start = 1'b1; b8.op = 3'd6; b8.value = 8'h00; b8.shamt = 3'd4;
    tick();
    b8.start = 1'b0; b8.MSB = 1'b1;
    tick();
    b8.MSB = 1'b0;
    b8.start = 1'b1; b8.op = 3'd0; b8.value = 8'hFF; b8.shamt = 3'd1;
    tick();
    b8.start = 1'b0; b8.MSB = 1'b1;
    tick();
    chk("srs_busy_e3", {31'd0, b8.busy}, 32'd1);
    chk("srs_done_e3", {31'd0, b8.done}, 32'd0);
    b8.MSB = 1'b1;
    tick();
    chk("srs_done_e4", {31'd0, b8.done}, 32'd1);
    chk("srs_Q", {24'd0, b8.Q}, 32'hD0);
    b8.MSB = 1'b0;
    tick();

    // shamt=0, then back-to-back starts taken in the done cycle.
    b8.start = 1'b1; b8.op = 3'd1; b8.value = 8'hA5; b8.shamt = 3'd0;
    tick();
    chk("z_done", {31'd0, b8.done}, 32'd1);
    chk("z_Q", {24'd0, b8.Q}, 32'hA5);
    chk("z_carry", {31'd0, b8.carry_out}, 32'd0);
    b8.op = 3'd0; b8.value = 8'h25; b8.shamt = 3'd2;
    tick();
    b8.start = 1'b0;
    chk("b2b_done_e0", {31'd0, b8.done}, 32'd0);
    chk("b2b_busy_e0", {31'd0, b8.busy}, 32'd1);
    tick();
    chk("b2b_done_e1", {31'd0, b8.done}, 32'd0);
    b8.start = 1'b1; b8.op = 3'd0; b8.value = 8'h3C; b8.shamt = 3'd0;
    tick();
    chk("b2b_done_e2", {31'd0, b8.done}, 32'd1);
    chk("b2b_Q", {24'd0, b8.Q}, 32'h94);
    tick();
    b8.start = 1'b0;
    chk("b2b_zero_done", {31'd0, b8.done}, 32'd1);
    chk("b2b_zero_Q", {24'd0, b8.Q}, 32'h3C);
    tick();
    chk("idle_done", {31'd0, b8.done}, 32'd0);

    // 32-bit, 4 bits per cycle.
    run32("sll32", 3'd0, 32'h0000_00FF, 5'd10, 32'h0003_FC00, 1'b0, 3);
    run32("ror32", 3'd4, 32'h0000_0012, 5'd5,  32'h9000_0000, 1'b1, 2);
    run32("sra32", 3'd2, 32'h8000_0001, 5'd7,  32'hFF00_0000, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got no summary expected summary");
    $fatal(1);
  end
endmodule
